// File: rtl/udp_pic_depacketizer.sv
// Strips the 6-byte picture header from UDP payloads, checks magic and byte offset continuity,
// and forwards RGB565 pixel bytes with start/done markers; rejected packets are counted.
module udp_pic_depacketizer #(
    parameter int unsigned PIC_BYTES = 12800,
    parameter logic [15:0] MAGIC     = 16'h55AA,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             rgmii_clk,
    input  logic             rst,
    input  logic [7:0]       udp_rx_data,
    input  logic             udp_rx_en,
    input  logic             udp_rx_done,
    output logic [7:0]       pix_data,
    output logic             pix_en,
    output logic             pix_sof,
    output logic             frame_done,
    output logic [7:0]       frame_id,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam logic [CNT_W-1:0] PIC_LEN  = CNT_W'(PIC_BYTES);
    localparam logic [CNT_W-1:0] PIC_LAST = CNT_W'(PIC_BYTES - 1);

    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

    state_t           state;
    logic [2:0]       hdr_idx;
    logic [7:0]       hdr_b0;
    logic [7:0]       hdr_fid;
    logic             hdr_sof;
    logic [7:0]       hdr_off_hi;
    logic [CNT_W-1:0] exp_off;
    logic             synced;
    logic             pic_full;
    logic             last_fwd;

    logic [15:0]      rx_off;
    logic             off_match;

    // Offset is complete when its low byte (b5) is on the bus.
    assign rx_off    = {hdr_off_hi, udp_rx_data};
    assign off_match = (CNT_W'(rx_off) == exp_off);

    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            state      <= HDR;
            hdr_idx    <= '0;
            hdr_b0     <= '0;
            hdr_fid    <= '0;
            hdr_sof    <= 1'b0;
            hdr_off_hi <= '0;
            exp_off    <= '0;
            synced     <= 1'b0;
            pic_full   <= 1'b0;
            last_fwd   <= 1'b0;
            pix_data   <= '0;
            pix_en     <= 1'b0;
            pix_sof    <= 1'b0;
            frame_done <= 1'b0;
            frame_id   <= '0;
            drop_cnt   <= '0;
        end else begin
            pix_en     <= 1'b0;
            pix_sof    <= 1'b0;
            frame_done <= last_fwd;
            last_fwd   <= 1'b0;

            case (state)
                HDR: begin
                    if (udp_rx_done) begin
                        // Payload ended before the header was complete.
                        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
                        hdr_idx <= '0;
                    end else if (udp_rx_en) begin
                        hdr_idx <= hdr_idx + 3'd1;
                        case (hdr_idx)
                            3'd0: hdr_b0 <= udp_rx_data;
                            3'd1: if ({hdr_b0, udp_rx_data} != MAGIC) state <= DROP;
                            3'd2: hdr_fid <= udp_rx_data;
                            3'd3: hdr_sof <= udp_rx_data[0];
                            3'd4: hdr_off_hi <= udp_rx_data;
                            3'd5: begin
                                if (hdr_sof && rx_off == 16'd0) begin
                                    // A SOF packet always (re)starts the picture, even mid-frame.
                                    exp_off  <= '0;
                                    synced   <= 1'b1;
                                    frame_id <= hdr_fid;
                                    state    <= PAYLOAD;
                                end else if (!hdr_sof && synced && off_match) begin
                                    state <= PAYLOAD;
                                end else begin
                                    if (!off_match) synced <= 1'b0;
                                    state <= DROP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                PAYLOAD: begin
                    if (udp_rx_done) begin
                        state    <= HDR;
                        hdr_idx  <= '0;
                        pic_full <= 1'b0;
                    end else if (udp_rx_en && !pic_full && exp_off < PIC_LEN) begin
                        pix_en   <= 1'b1;
                        pix_data <= udp_rx_data;
                        pix_sof  <= (exp_off == '0);
                        if (exp_off == PIC_LAST) begin
                            // Picture complete: swallow any trailing bytes of this packet.
                            exp_off  <= '0;
                            synced   <= 1'b0;
                            pic_full <= 1'b1;
                            last_fwd <= 1'b1;
                        end else begin
                            exp_off <= exp_off + CNT_W'(1);
                        end
                    end
                end

                DROP: begin
                    if (udp_rx_done) begin
                        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
                        state   <= HDR;
                        hdr_idx <= '0;
                    end
                end

                default: state <= HDR;
            endcase
        end
    end
endmodule
